kilit_adim_sayaci: RTL
======================

KILIT_ADIM_SAYACI -- requirements
Module: kilit_adim_sayaci

Interface
REQ-001 The block SHALL have parameter KILIT_SURESI, default 16, meaning lockout duration in clock cycles (range 1..255).
REQ-002 The block SHALL have parameter HATA_LIMITI, default 3, meaning consecutive failed attempts that trigger lockout (range 1..3).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 sag_btn  input  1  right-step button level, synchronous to clk.
REQ-006 sol_btn  input  1  left-step button level, synchronous to clk.
REQ-007 onay_btn  input  1  confirm button level, synchronous to clk.
REQ-008 iptal  input  1  cancel level; clears the entry in progress.
REQ-009 kilitler_acik  input  1  combinational verdict from the downstream dual-lock checker.
REQ-010 sag_adimlar  output  6  right-step counts: [5:3] = lock 1, [2:0] = lock 0.
REQ-011 sol_adimlar  output  4  left-step counts: [3:2] = lock 1, [1:0] = lock 0.
REQ-012 giris_hazir  output  1  high when the count outputs are complete and kilitler_acik is being sampled.
REQ-013 acik  output  1  lock open.
REQ-014 kilitli  output  1  lockout active.
REQ-015 hata_sayisi  output  2  consecutive failure count.

Function
REQ-016 The block SHALL detect each button press internally as a rising edge (level high this cycle, low the previous cycle), giving one event per press.
REQ-017 The FSM SHALL have the states BOSTA, KILIT1, KILIT0, KONTROL, ACIK and KILITLI.
REQ-018 BOSTA: an onay edge SHALL clear both count outputs and go to KILIT1; sag and sol edges SHALL be ignored.
REQ-019 KILIT1: each sag edge SHALL increment sag_adimlar[5:3] and each sol edge SHALL increment sol_adimlar[3:2]; an onay edge SHALL go to KILIT0.
REQ-020 KILIT0: each sag edge SHALL increment sag_adimlar[2:0] and each sol edge SHALL increment sol_adimlar[1:0]; an onay edge SHALL go to KONTROL.
REQ-021 Counters SHALL saturate at 7 (right) and 3 (left), with no wrap-around.
REQ-022 Simultaneous sag and sol edges SHALL both be counted in the same cycle.
REQ-023 When an onay edge coincides with a sag or sol edge, the state SHALL advance and the step edge SHALL be discarded.
REQ-024 KONTROL SHALL last exactly one cycle, with giris_hazir = 1 and kilitler_acik sampled at the end of that cycle.
REQ-025 On kilitler_acik = 1 in KONTROL, the FSM SHALL go to ACIK and clear hata_sayisi.
REQ-026 On kilitler_acik = 0 in KONTROL, hata_sayisi SHALL increment (saturating) and the FSM SHALL go to BOSTA, or to KILITLI per REQ-033.
REQ-027 Latency: an onay edge in KILIT0 at cycle N SHALL give giris_hazir high in cycle N+1 and acik high from cycle N+2.
REQ-028 ACIK: acik SHALL be 1; an onay edge SHALL clear the counts and return to BOSTA.
REQ-029 iptal high in KILIT1 or KILIT0 SHALL return to BOSTA with counts cleared and no failure counted; iptal SHALL have priority over every button edge in the same cycle.
REQ-030 iptal SHALL be ignored in BOSTA, KONTROL, ACIK and KILITLI.
REQ-031 Count outputs SHALL hold their values in KONTROL and ACIK.

Reset
REQ-032 While rst is high: state SHALL be BOSTA, sag_adimlar = 0, sol_adimlar = 0, giris_hazir = 0, acik = 0, kilitli = 0, hata_sayisi = 0, edge-detect registers = 0, lockout timer = 0. This SHALL apply from any state, including mid-entry and mid-lockout.

Configuration
REQ-033 With KILIT_KILITLEME_EN defined: a failure that makes hata_sayisi equal HATA_LIMITI SHALL enter KILITLI. In KILITLI, kilitli = 1 and all inputs are ignored for exactly KILIT_SURESI cycles; the FSM then goes to BOSTA with hata_sayisi = 0.
REQ-034 Without KILIT_KILITLEME_EN: KILITLI and its timer SHALL be absent, kilitli SHALL be tied to 0, and failures SHALL always return to BOSTA.

Structure
REQ-035 The shared package kilit_pkg SHALL hold the state encodings, the count field widths (3 and 2) and the default values of HATA_LIMITI and KILIT_SURESI.
REQ-036 The rising-edge detector SHALL be one sub-module, kenar_algilayici, instantiated three times (sag, sol, onay).

Verification
REQ-037 Scenario 1: onay; lock 1 gets 3 sag + 1 sol; onay; lock 0 gets 5 sag + 0 sol; onay -> sag_adimlar = 6'h1D, sol_adimlar = 4'b0100, giris_hazir pulses for one cycle.
REQ-038 Scenario 2: as scenario 1 with the bench driving kilitler_acik = 1 during KONTROL -> acik = 1 two cycles after the final onay edge and hata_sayisi = 0; a further onay -> acik = 0, state BOSTA.
REQ-039 Scenario 3: 9 sag presses in KILIT1 -> sag_adimlar[5:3] = 7; sag and sol high in the same cycle -> both fields increment.
REQ-040 Scenario 4 (KILIT_KILITLEME_EN defined): 3 attempts with kilitler_acik = 0 -> kilitli = 1 for exactly 16 cycles with button presses ignored; then BOSTA and hata_sayisi = 0.
REQ-041 Scenario 5: iptal in KILIT0 after 2 sag presses -> BOSTA, counts = 0, hata_sayisi unchanged.
REQ-042 Scenario 6: rst asserted asynchronously mid-KILITLI and mid-KILIT1 -> all outputs 0 immediately, state BOSTA.

Source files
------------

// File: rtl/kilit_adim_sayaci_pkg.sv
// kilit_pkg -- shared definitions for the dual-lock step counter.
// Holds the FSM state encodings, the per-lock count field widths, the
// saturation limits and the default lockout parameters, plus the small
// saturating-increment helpers used by kilit_adim_sayaci.
package kilit_pkg;

   // Count field widths: three bits per right-step field, two per left-step field
   localparam int SAG_ALAN_W = 3;
   localparam int SOL_ALAN_W = 2;
   localparam int HATA_W     = 2;
   localparam int DURUM_W    = 3;
   localparam int ZAMAN_W    = 8;

   // Default configuration values for the top-level parameters
   localparam int HATA_LIMITI_VARSAYILAN  = 3;
   localparam int KILIT_SURESI_VARSAYILAN = 16;

   // FSM state encodings (plain constants so older code can compare against them)
   localparam logic [DURUM_W-1:0] BOSTA   = 3'd0;
   localparam logic [DURUM_W-1:0] KILIT1  = 3'd1;
   localparam logic [DURUM_W-1:0] KILIT0  = 3'd2;
   localparam logic [DURUM_W-1:0] KONTROL = 3'd3;
   localparam logic [DURUM_W-1:0] ACIK    = 3'd4;
   localparam logic [DURUM_W-1:0] KILITLI = 3'd5;

   // Saturation ceilings: counters stick here instead of wrapping
   localparam logic [SAG_ALAN_W-1:0] SAG_TAVAN  = 3'd7;
   localparam logic [SOL_ALAN_W-1:0] SOL_TAVAN  = 2'd3;
   localparam logic [HATA_W-1:0]     HATA_TAVAN = 2'd3;

   // Right-step field: add one on an edge, hold at the ceiling
   function automatic logic [SAG_ALAN_W-1:0] sag_adim_arttir(
      input logic [SAG_ALAN_W-1:0] deger,
      input logic                  etkin
   );
      logic [SAG_ALAN_W-1:0] sonuc;
      if (etkin && (deger != SAG_TAVAN)) begin
         sonuc = deger + 3'd1;
      end else begin
         sonuc = deger;
      end
      return sonuc;
   endfunction

   // Left-step field: add one on an edge, hold at the ceiling
   function automatic logic [SOL_ALAN_W-1:0] sol_adim_arttir(
      input logic [SOL_ALAN_W-1:0] deger,
      input logic                  etkin
   );
      logic [SOL_ALAN_W-1:0] sonuc;
      if (etkin && (deger != SOL_TAVAN)) begin
         sonuc = deger + 2'd1;
      end else begin
         sonuc = deger;
      end
      return sonuc;
   endfunction

   // Consecutive-failure count: add one, hold at the ceiling
   function automatic logic [HATA_W-1:0] hata_arttir(
      input logic [HATA_W-1:0] deger
   );
      logic [HATA_W-1:0] sonuc;
      if (deger != HATA_TAVAN) begin
         sonuc = deger + 2'd1;
      end else begin
         sonuc = deger;
      end
      return sonuc;
   endfunction

endpackage

// File: rtl/kenar_algilayici.sv
// kenar_algilayici -- rising-edge detector for one button level.
// The edge output is high in the cycle where the level is high and was
// low the cycle before, so a held button yields exactly one event.
module kenar_algilayici (
   input  logic clk,
   input  logic rst,
   input  logic seviye,
   output logic kenar
);

   logic onceki_r;

   // Remember the previous cycle's button level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         onceki_r <= 1'b0;
      end else begin
         onceki_r <= seviye;
      end
   end

   assign kenar = seviye & ~onceki_r;

endmodule

// File: rtl/kilit_adim_sayaci.sv
// kilit_adim_sayaci -- step-count entry for a dual combination lock.
// The user confirms into lock 1, enters right/left steps, confirms into
// lock 0, enters steps, and confirms again; the counts are then presented
// for one cycle (giris_hazir) while the downstream verdict is sampled.
// Optional feature macro: KILIT_KILITLEME_EN -- when defined, reaching
// HATA_LIMITI consecutive failures enters a timed KILITLI lockout state.
module kilit_adim_sayaci
   import kilit_pkg::*;
#(
   parameter int KILIT_SURESI = KILIT_SURESI_VARSAYILAN,
   parameter int HATA_LIMITI  = HATA_LIMITI_VARSAYILAN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sag_btn,
   input  logic       sol_btn,
   input  logic       onay_btn,
   input  logic       iptal,
   input  logic       kilitler_acik,
   output logic [5:0] sag_adimlar,
   output logic [3:0] sol_adimlar,
   output logic       giris_hazir,
   output logic       acik,
   output logic       kilitli,
   output logic [1:0] hata_sayisi
);

   // Reject configurations outside the supported ranges at elaboration
   if ((KILIT_SURESI < 1) || (KILIT_SURESI > 255) ||
       (HATA_LIMITI < 1) || (HATA_LIMITI > 3)) begin : g_parametre_hatasi
      $error("kilit_adim_sayaci: KILIT_SURESI or HATA_LIMITI out of range");
   end

   logic                  sag_kenar_s;
   logic                  sol_kenar_s;
   logic                  onay_kenar_s;

   logic [DURUM_W-1:0]    durum_r;
   logic [DURUM_W-1:0]    durum_sonraki_s;
   logic [5:0]            sag_r;
   logic [5:0]            sag_sonraki_s;
   logic [3:0]            sol_r;
   logic [3:0]            sol_sonraki_s;
   logic [HATA_W-1:0]     hata_r;
   logic [HATA_W-1:0]     hata_sonraki_s;
   logic [HATA_W-1:0]     hata_artmis_s;
   logic                  giris_hazir_r;
   logic                  acik_r;

`ifdef KILIT_KILITLEME_EN
   localparam logic [HATA_W-1:0]  HATA_LIMITI_Y  = HATA_W'(HATA_LIMITI);
   localparam logic [ZAMAN_W-1:0] KILIT_YUKLEME  = ZAMAN_W'(KILIT_SURESI - 1);

   logic [ZAMAN_W-1:0]    zaman_r;
   logic [ZAMAN_W-1:0]    zaman_sonraki_s;
   logic                  kilitli_r;
`endif

   kenar_algilayici u_sag_kenar (
      .clk    (clk),
      .rst    (rst),
      .seviye (sag_btn),
      .kenar  (sag_kenar_s)
   );

   kenar_algilayici u_sol_kenar (
      .clk    (clk),
      .rst    (rst),
      .seviye (sol_btn),
      .kenar  (sol_kenar_s)
   );

   kenar_algilayici u_onay_kenar (
      .clk    (clk),
      .rst    (rst),
      .seviye (onay_btn),
      .kenar  (onay_kenar_s)
   );

   assign hata_artmis_s = hata_arttir(hata_r);

   // Next-state, count and failure-counter decisions for the entry FSM
   always_comb begin
      durum_sonraki_s = durum_r;
      sag_sonraki_s   = sag_r;
      sol_sonraki_s   = sol_r;
      hata_sonraki_s  = hata_r;
`ifdef KILIT_KILITLEME_EN
      zaman_sonraki_s = zaman_r;
`endif
      case (durum_r)
         BOSTA: begin
            // step edges are meaningless before an entry has started
            if (onay_kenar_s) begin
               sag_sonraki_s   = 6'd0;
               sol_sonraki_s   = 4'd0;
               durum_sonraki_s = KILIT1;
            end else begin
               durum_sonraki_s = BOSTA;
            end
         end
         KILIT1, KILIT0: begin
            // cancel outranks everything; a confirm swallows a coincident step
            if (iptal) begin
               sag_sonraki_s   = 6'd0;
               sol_sonraki_s   = 4'd0;
               durum_sonraki_s = BOSTA;
            end else if (onay_kenar_s) begin
               if (durum_r == KILIT1) begin
                  durum_sonraki_s = KILIT0;
               end else begin
                  durum_sonraki_s = KONTROL;
               end
            end else if (durum_r == KILIT1) begin
               sag_sonraki_s[5:3] = sag_adim_arttir(sag_r[5:3], sag_kenar_s);
               sol_sonraki_s[3:2] = sol_adim_arttir(sol_r[3:2], sol_kenar_s);
            end else begin
               sag_sonraki_s[2:0] = sag_adim_arttir(sag_r[2:0], sag_kenar_s);
               sol_sonraki_s[1:0] = sol_adim_arttir(sol_r[1:0], sol_kenar_s);
            end
         end
         KONTROL: begin
            // single-cycle verdict: counts are frozen while the checker looks
            if (kilitler_acik) begin
               hata_sonraki_s  = 2'd0;
               durum_sonraki_s = ACIK;
            end else begin
               hata_sonraki_s  = hata_artmis_s;
`ifdef KILIT_KILITLEME_EN
               if (hata_artmis_s == HATA_LIMITI_Y) begin
                  zaman_sonraki_s = KILIT_YUKLEME;
                  durum_sonraki_s = KILITLI;
               end else begin
                  durum_sonraki_s = BOSTA;
               end
`else
               durum_sonraki_s = BOSTA;
`endif
            end
         end
         ACIK: begin
            if (onay_kenar_s) begin
               sag_sonraki_s   = 6'd0;
               sol_sonraki_s   = 4'd0;
               durum_sonraki_s = BOSTA;
            end else begin
               durum_sonraki_s = ACIK;
            end
         end
`ifdef KILIT_KILITLEME_EN
         KILITLI: begin
            // timer was loaded with duration-1, so zero marks the last cycle
            if (zaman_r == 8'd0) begin
               hata_sonraki_s  = 2'd0;
               durum_sonraki_s = BOSTA;
            end else begin
               zaman_sonraki_s = zaman_r - 8'd1;
            end
         end
`endif
         default: begin
            durum_sonraki_s = BOSTA;
            sag_sonraki_s   = 6'd0;
            sol_sonraki_s   = 4'd0;
         end
      endcase
   end

   // State, counts and the state-derived status outputs, all registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         durum_r       <= BOSTA;
         sag_r         <= 6'd0;
         sol_r         <= 4'd0;
         hata_r        <= 2'd0;
         giris_hazir_r <= 1'b0;
         acik_r        <= 1'b0;
      end else begin
         durum_r       <= durum_sonraki_s;
         sag_r         <= sag_sonraki_s;
         sol_r         <= sol_sonraki_s;
         hata_r        <= hata_sonraki_s;
         giris_hazir_r <= (durum_sonraki_s == KONTROL);
         acik_r        <= (durum_sonraki_s == ACIK);
      end
   end

`ifdef KILIT_KILITLEME_EN
   // Lockout timer and its registered status flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zaman_r   <= 8'd0;
         kilitli_r <= 1'b0;
      end else begin
         zaman_r   <= zaman_sonraki_s;
         kilitli_r <= (durum_sonraki_s == KILITLI);
      end
   end

   assign kilitli = kilitli_r;
`else
   assign kilitli = 1'b0;
`endif

   assign sag_adimlar = sag_r;
   assign sol_adimlar = sol_r;
   assign hata_sayisi = hata_r;
   assign giris_hazir = giris_hazir_r;
   assign acik        = acik_r;

endmodule
